// File: rtl/lab9_soc_pio_pkg.sv
// rtl/lab9_soc_pio_pkg.sv - register map and mode encodings shared by the input PIO slice
package lab9_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/lab9_soc_pio_in_edge_if.sv
// rtl/lab9_soc_pio_in_edge_if.sv - Avalon-MM slave bus plus interrupt line of the input PIO
interface lab9_soc_pio_in_edge_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/lab9_soc_sync_vec.sv
// rtl/lab9_soc_sync_vec.sv - WIDTH x SYNC_STAGES flop-chain synchroniser, async reset to 0
module lab9_soc_sync_vec #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/lab9_soc_pio_in_edge.sv
// rtl/lab9_soc_pio_in_edge.sv - input PIO slave: synchronised data, edge capture, mask and IRQ
module lab9_soc_pio_in_edge
  import lab9_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_port,
  lab9_soc_pio_in_edge_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_param
    $error("lab9_soc_pio_in_edge: WIDTH must be 1..32 and SYNC_STAGES 2..4");
  end

  if (WIDTH < 32) begin : g_unused_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
  end

  localparam int                 PRIME_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   sync;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   edge_cap;
  logic [WIDTH-1:0]   edge_hit;
  logic [WIDTH-1:0]   edge_clr;
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;
  logic               wr_en;
  logic               irq_next;
  logic [31:0]        rd_next;

  lab9_soc_sync_vec #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync)
  );

  // prev only becomes meaningful once the chain has flushed the reset zeros
  assign primed = (prime_cnt == PRIME_MAX);
  assign wr_en  = bus.chipselect & ~bus.write_n;

  always_comb begin
    edge_hit = '0;
    if (primed) begin
      case (EDGE_TYPE)
        EDGE_RISE: edge_hit = sync & ~prev;
        EDGE_FALL: edge_hit = ~sync & prev;
        default:   edge_hit = sync ^ prev;
      endcase
    end
  end

  always_comb begin
    edge_clr = '0;
    if (wr_en && bus.address == ADDR_EDGE) begin
      edge_clr = bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA: rd_next[WIDTH-1:0] = sync;
      ADDR_MASK: rd_next[WIDTH-1:0] = mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_cap;
      default:   rd_next = '0;
    endcase
  end

  assign irq_next = (IRQ_MODE == IRQ_LEVEL) ? |(sync & mask) : |(edge_cap & mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= '0;
      mask         <= '0;
      edge_cap     <= '0;
      prime_cnt    <= '0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      prev <= sync;
      if (!primed) begin
        prime_cnt <= prime_cnt + PRIME_W'(1);
      end
      if (wr_en && bus.address == ADDR_MASK) begin
        mask <= bus.writedata[WIDTH-1:0];
      end
      // a new edge in the same cycle as its clear is kept
      edge_cap     <= (edge_cap & ~edge_clr) | edge_hit;
      bus.readdata <= rd_next;
      bus.irq      <= irq_next;
    end
  end

endmodule

// File: tb/tb_lab9_soc_pio_in_edge.sv
// tb/tb_lab9_soc_pio_in_edge.sv - three parameter variants driven in lockstep against a history-based model
module tb_lab9_soc_pio_in_edge;

  localparam int SS = 2;

  logic        clk;
  logic        reset;
  logic [7:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  logic [31:0] rd_o  [3];
  logic        irq_o [3];

  int vectors;
  int miscompares;

  // model: every in_port sample taken since reset, plus per-variant registers
  logic [7:0]  seen [$];
  logic [7:0]  m_mask;
  logic [7:0]  m_cap [3];
  logic [31:0] m_rd  [3];
  logic        m_irq [3];

  lab9_soc_pio_in_edge_if bus0 ();
  lab9_soc_pio_in_edge_if bus1 ();
  lab9_soc_pio_in_edge_if bus2 ();

  assign bus0.address = address;  assign bus0.chipselect = chipselect;
  assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
  assign bus1.address = address;  assign bus1.chipselect = chipselect;
  assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
  assign bus2.address = address;  assign bus2.chipselect = chipselect;
  assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;

  assign rd_o[0] = bus0.readdata;  assign irq_o[0] = bus0.irq;
  assign rd_o[1] = bus1.readdata;  assign irq_o[1] = bus1.irq;
  assign rd_o[2] = bus2.readdata;  assign irq_o[2] = bus2.irq;

  lab9_soc_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(0), .IRQ_MODE(1)) u0 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus0));
  lab9_soc_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(2), .IRQ_MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus1));
  lab9_soc_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SS), .EDGE_TYPE(1), .IRQ_MODE(0)) u2 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int edge_type_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 1;
  endfunction

  function automatic int irq_mode_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    seen.delete();
    m_mask = 8'h00;
    for (int k = 0; k < 3; k++) begin
      m_cap[k] = 8'h00;
      m_rd[k]  = 32'h0;
      m_irq[k] = 1'b0;
    end
  endtask

  // one clock: predict from the spec rules, advance, then compare every output
  task automatic step();
    int          n;
    logic [7:0]  s_now, p_now, hit, clr, mask_n;
    logic [7:0]  cap_n [3];
    logic [31:0] rd_n  [3];
    logic        irq_n [3];
    bit          wr;
    n      = seen.size();
    s_now  = (n >= SS)     ? seen[n-SS]   : 8'h00;
    p_now  = (n >= SS + 1) ? seen[n-SS-1] : 8'h00;
    wr     = chipselect && !write_n;
    clr    = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
    mask_n = (wr && address == 2'd2) ? writedata[7:0] : m_mask;
    for (int k = 0; k < 3; k++) begin
      hit = 8'h00;
      if (n >= SS + 1) begin
        case (edge_type_of(k))
          0:       hit = s_now & ~p_now;
          1:       hit = ~s_now & p_now;
          default: hit = s_now ^ p_now;
        endcase
      end
      cap_n[k] = (m_cap[k] & ~clr) | hit;
      case (address)
        2'd0:    rd_n[k] = {24'h0, s_now};
        2'd2:    rd_n[k] = {24'h0, m_mask};
        2'd3:    rd_n[k] = {24'h0, m_cap[k]};
        default: rd_n[k] = 32'h0;
      endcase
      irq_n[k] = (irq_mode_of(k) == 0) ? |(s_now & m_mask) : |(m_cap[k] & m_mask);
    end
    seen.push_back(in_port);
    @(posedge clk);
    #1;
    m_mask = mask_n;
    for (int k = 0; k < 3; k++) begin
      m_cap[k] = cap_n[k];
      m_rd[k]  = rd_n[k];
      m_irq[k] = irq_n[k];
      chk($sformatf("readdata[u%0d]", k), rd_o[k], m_rd[k]);
      chk($sformatf("irq[u%0d]", k), 32'(irq_o[k]), 32'(m_irq[k]));
    end
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic wr_step(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_port     = 8'hA5;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'h0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_rd[u%0d]", k), rd_o[k], 32'h0);
      chk($sformatf("reset_irq[u%0d]", k), 32'(irq_o[k]), 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // data latency and priming with inputs already high at release
    steps(3);
    chk("data_latency", rd_o[0], 32'h000000A5);
    address = 2'd3;
    steps(2);
    chk("prime_rise", rd_o[0], 32'h0);
    chk("prime_any", rd_o[1], 32'h0);

    // rising capture, write-1-to-clear
    in_port = 8'h00; steps(4);
    in_port = 8'h03; steps(4);
    in_port = 8'h01; steps(4);
    chk("edge_rise_03", rd_o[0], 32'h03);
    wr_step(2'd3, 32'h01);
    step();
    chk("edge_clr_01", rd_o[0], 32'h02);
    wr_step(2'd3, 32'hFF);
    step();
    chk("edge_clr_ff", rd_o[0], 32'h0);

    // edge-mode irq through mask bit 7
    wr_step(2'd2, 32'h80);
    address = 2'd3;
    in_port = 8'h81; steps(4);
    chk("irq_edge_u0", 32'(irq_o[0]), 32'h1);
    chk("irq_edge_u1", 32'(irq_o[1]), 32'h1);
    wr_step(2'd3, 32'h80);
    step();
    chk("irq_clr_u0", 32'(irq_o[0]), 32'h0);
    chk("irq_clr_u1", 32'(irq_o[1]), 32'h0);
    in_port = 8'h80; steps(4);
    chk("irq_masked_fall", 32'(irq_o[1]), 32'h0);
    in_port = 8'h81; steps(4);
    chk("irq_masked_rise", 32'(irq_o[0]), 32'h0);

    // clear and rising edge of bit 4 in the same clock
    wr_step(2'd2, 32'h10);
    address = 2'd3;
    in_port = 8'h91;
    steps(2);
    wr_step(2'd3, 32'h10);
    step();
    chk("set_wins", rd_o[0] & 32'h10, 32'h10);
    chk("set_wins_irq", 32'(irq_o[0]), 32'h1);

    // level-mode irq and mask deassertion
    in_port = 8'h90; steps(4);
    wr_step(2'd2, 32'h01);
    in_port = 8'h91;
    steps(2);
    chk("level_early", 32'(irq_o[2]), 32'h0);
    step();
    chk("level_irq", 32'(irq_o[2]), 32'h1);
    wr_step(2'd2, 32'h0);
    step();
    chk("mask_off_irq", 32'(irq_o[2]), 32'h0);
    wr_step(2'd0, 32'hFFFFFFFF);
    wr_step(2'd1, 32'hFFFFFFFF);
    address = 2'd2; step();
    chk("mask_unchanged", rd_o[0], 32'h0);
    address = 2'd1; step();
    chk("reserved_zero", rd_o[1], 32'h0);
    address = 2'd0; step();
    chk("data_unchanged", rd_o[2], 32'h91);

    // random bus traffic and input activity
    for (int i = 0; i < 400; i++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom();
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom());
      step();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // asynchronous reset with captures and irq pending
    wr_step(2'd2, 32'hFF);
    address = 2'd3;
    in_port = 8'h00; steps(4);
    in_port = 8'hFF; steps(4);
    in_port = 8'h00; steps(4);
    chk("pre_reset_irq_u0", 32'(irq_o[0]), 32'h1);
    chk("pre_reset_irq_u1", 32'(irq_o[1]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_rd[u%0d]", k), rd_o[k], 32'h0);
      chk($sformatf("async_irq[u%0d]", k), 32'(irq_o[k]), 32'h0);
    end
    model_reset();
    address = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mask_rd", rd_o[0], 32'h0);
    @(negedge clk);
    reset   = 1'b0;
    address = 2'd3;
    steps(8);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_reset_edge[u%0d]", k), rd_o[k], 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lab9_soc_pio_in_edge.md
Name: lab9_soc_pio_in_edge

Overview:
- Parametrised Avalon-MM input PIO slave, successor to the single-bit input port.
- WIDTH-bit input bus with metastability synchroniser, per-bit edge capture, interrupt mask and IRQ generation.
- Sits between board inputs (keys, switches, reset buttons) and the Nios II data master; the IRQ goes to the CPU interrupt controller.

Parameters:
- WIDTH, 8: input bus width, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- EDGE_TYPE, 0: edge that sets a capture bit; 0 = rising, 1 = falling, 2 = any.
- IRQ_MODE, 1: 0 = level (irq from synchronised data & mask), 1 = edge (irq from capture & mask).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous board inputs.
- readdata  out  32  registered read data.
- irq  out  1  registered interrupt request, active-high.

Behaviour:
- Reset values: all synchroniser flops, prev, mask, edge_cap, the prime counter, readdata and irq are 0.
- Synchroniser: in_port passes through a SYNC_STAGES-deep flop chain to give sync. prev is sync delayed by one clk.
- Register map (readdata bits above WIDTH read 0):
  - addr 0 DATA, read-only: sync. Writes are ignored.
  - addr 1 reserved: reads 0, writes ignored.
  - addr 2 MASK, read/write: a write loads writedata[WIDTH-1:0].
  - addr 3 EDGE, read / write-1-to-clear: for each bit i with writedata[i]=1, edge_cap[i] is cleared.
- Read path:
  - readdata is registered every clk from address with no read strobe; latency is 1 clk.
  - readdata does not depend on chipselect.
- Latency from in_port to DATA: an in_port change appears in readdata (addr 0 held) SYNC_STAGES+1 clk edges later.
- Edge detect:
  - rise[i] = sync[i] & ~prev[i]; fall[i] = ~sync[i] & prev[i].
  - The EDGE_TYPE selection sets edge_cap[i] at the same clk edge.
  - Capture bits are sticky until cleared.
- Prime counter:
  - Counts 0..SYNC_STAGES+1 after reset, then saturates.
  - Edge detection is suppressed until it saturates, so inputs already asserted at reset release do not produce a spurious capture.
- Simultaneous clear and edge on the same bit, same clk: set wins and edge_cap[i] = 1.
- IRQ:
  - IRQ_MODE=0: irq <= |(sync & mask).
  - IRQ_MODE=1: irq <= |(edge_cap & mask).
  - The value is registered, so it lags the cause by 1 clk.
  - Writing MASK=0 deasserts irq on the next clk.
- Readback after writes: writing MASK then reading MASK returns the new value on the read that follows the write cycle. Read-during-write to the same address returns the old value.
- Reset mid-operation: asynchronous assert clears all state immediately, including any pending edge_cap and irq. Priming restarts on release.
- Parameter elaboration check: WIDTH>32 or SYNC_STAGES<2 is an error.

Decomposition:
- Shared package lab9_soc_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
  - EDGE_RISE/EDGE_FALL/EDGE_ANY and IRQ_LEVEL/IRQ_EDGE encodings.
- Sub-module lab9_soc_sync_vec: parametrised WIDTH x SYNC_STAGES synchroniser with asynchronous reset to 0.
- All remaining logic lives in the top module.

Test Plan (WIDTH=8, SYNC_STAGES=2):
- Reset, then in_port=8'hA5 held, address=0 -> readdata=32'h000000A5 three clk after the in_port change; EDGE reads 0 if 8'hA5 was applied during reset (priming).
- EDGE_TYPE=0: after priming, in_port 8'h00 -> 8'h03 -> 8'h01 -> EDGE=8'h03. Write EDGE 32'h01 -> EDGE=8'h02. Write 32'hFF -> EDGE=0.
- EDGE_TYPE=2, IRQ_MODE=1, MASK=8'h80: toggle in_port[7] -> irq=1 one clk after edge_cap[7] sets. Write EDGE 32'h80 -> irq=0 next clk. Toggle in_port[0] only -> irq stays 0.
- Simultaneous events: a rising edge on bit 4 arrives in the same clk as a write EDGE 32'h10 -> edge_cap[4]=1 afterward, and irq follows per mask.
- IRQ_MODE=0, MASK=8'h01: in_port[0]=1 -> irq=1 after 3 clk. Write MASK=0 -> irq=0 next clk. Writes to addr 0 and addr 1 change nothing.
- Reset asserted mid-operation with EDGE=8'hFF, MASK=8'hFF, irq=1 -> readdata, irq and all registers read 0 immediately (asynchronous). After release, no capture occurs while in_port is held constant.
